r2r_ramp_generator: RTL and testbench

- Upstream stage of the ramp ADC. Generates the 8-bit code that drives the R2R ladder DAC and the downstream fall-detector's R2R_output input.
- The code steps at a programmable rate, in sawtooth or triangle form.
- Supplies a per-step strobe and an end-of-sweep strobe so downstream capture and averaging logic can frame conversions.

---
 rtl/adc_pkg.sv | 16 +
 rtl/r2r_ramp_generator_step_prescaler.sv | 41 ++++
 rtl/r2r_ramp_generator.sv | 116 +++++++++++
 tb/tb_r2r_ramp_generator.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ramp ADC front end.
package adc_pkg;

    localparam int unsigned R2R_WIDTH = 8;

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_dir_t;

    typedef enum logic {
        RAMP_SAW = 1'b0,
        RAMP_TRI = 1'b1
    } ramp_mode_t;

endpackage

// File: rtl/r2r_ramp_generator_step_prescaler.sv
// Divides the system clock down to one ramp-step tick every STEP_DIV enabled cycles.
module step_prescaler #(
    parameter int unsigned STEP_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    // Tick is combinational so the step lands on the same edge the count wraps.
    assign tick = enable && !clear && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/r2r_ramp_generator.sv
// Sawtooth / triangle code generator for the R2R ladder DAC, with step and
// end-of-sweep strobes aligned to the code update.
module r2r_ramp_generator
    import adc_pkg::*;
#(
    parameter int unsigned WIDTH    = R2R_WIDTH,
    parameter int unsigned STEP_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic             triangle_mode,
    output logic [WIDTH-1:0] R2R_output,
    output logic             ramp_dir,
    output logic             step_strobe,
    output logic             sweep_done
);

    localparam logic [WIDTH-1:0] CODE_MAX = '1;
    localparam logic [WIDTH-1:0] CODE_ONE = WIDTH'(1);

    logic             tick;
    logic [WIDTH-1:0] code_q, code_d;
    ramp_dir_t        dir_q, dir_d;
    ramp_mode_t       mode_q, mode_d;
    logic             step_q, step_d;
    logic             done_q, done_d;

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (restart),
        .tick   (tick)
    );

    always_comb begin
        code_d = code_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        step_d = 1'b0;
        done_d = 1'b0;

        if (restart) begin
            code_d = '0;
            dir_d  = RAMP_UP;
            mode_d = ramp_mode_t'(triangle_mode);
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                RAMP_SAW: begin
                    if (code_q == CODE_MAX) begin
                        code_d = '0;
                        done_d = 1'b1;
                    end else begin
                        code_d = code_q + CODE_ONE;
                    end
                end
                RAMP_TRI: begin
                    if (dir_q == RAMP_UP) begin
                        if (code_q == CODE_MAX) begin
                            dir_d  = RAMP_DOWN;
                            code_d = CODE_MAX - CODE_ONE;
                        end else begin
                            code_d = code_q + CODE_ONE;
                        end
                    end else begin
                        // Down at 0 only occurs after a completed triangle sweep.
                        if (code_q > CODE_ONE) begin
                            code_d = code_q - CODE_ONE;
                        end else if (code_q == CODE_ONE) begin
                            code_d = '0;
                            done_d = 1'b1;
                        end else begin
                            dir_d  = RAMP_UP;
                            code_d = CODE_ONE;
                        end
                    end
                end
                default: ;
            endcase

            if (done_d) begin
                mode_d = ramp_mode_t'(triangle_mode);
                if (mode_d == RAMP_SAW) begin
                    dir_d = RAMP_UP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q <= '0;
            dir_q  <= RAMP_UP;
            mode_q <= RAMP_SAW;
            step_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            code_q <= code_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            step_q <= step_d;
            done_q <= done_d;
        end
    end

    assign R2R_output  = code_q;
    assign ramp_dir    = (dir_q == RAMP_DOWN);
    assign step_strobe = step_q;
    assign sweep_done  = done_q;

endmodule

// File: tb/tb_r2r_ramp_generator.sv
// Self-checking bench for r2r_ramp_generator (WIDTH=8, STEP_DIV=4).
module tb_r2r_ramp_generator;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned STEP_DIV = 4;
    localparam int          MAXC     = 255;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             restart;
    logic             triangle_mode;
    logic [WIDTH-1:0] R2R_output;
    logic             ramp_dir;
    logic             step_strobe;
    logic             sweep_done;

    int n_tests;
    int n_fail;

    r2r_ramp_generator #(
        .WIDTH    (WIDTH),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .restart       (restart),
        .triangle_mode (triangle_mode),
        .R2R_output    (R2R_output),
        .ramp_dir      (ramp_dir),
        .step_strobe   (step_strobe),
        .sweep_done    (sweep_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: position k within the current sweep, not code/dir registers.
    int m_cnt;
    int m_k;
    int m_tri;
    int m_dir0;
    int m_step;
    int m_done;

    function automatic int m_code();
        if (m_tri != 0 && m_k > MAXC) return 2 * MAXC - m_k;
        return m_k;
    endfunction

    function automatic int m_dir();
        if (m_k == 0) return m_dir0;
        return (m_tri != 0 && m_k > MAXC) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_k    = 0;
        m_tri  = 0;
        m_dir0 = 0;
        m_step = 0;
        m_done = 0;
    endtask

    task automatic model_edge(input logic rs, input logic en, input logic tm);
        int sweep_len;
        m_step = 0;
        m_done = 0;
        if (rs) begin
            m_cnt  = 0;
            m_k    = 0;
            m_dir0 = 0;
            m_tri  = int'(tm);
        end else if (en) begin
            if (m_cnt == STEP_DIV - 1) begin
                m_cnt  = 0;
                m_step = 1;
                m_k    = m_k + 1;
                sweep_len = (m_tri != 0) ? 2 * MAXC : MAXC + 1;
                if (m_k == sweep_len) begin
                    m_k    = 0;
                    m_done = 1;
                    m_dir0 = (m_tri != 0 && tm) ? 1 : 0;
                    m_tri  = int'(tm);
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name, input int code, input int dir,
                                 input int stp, input int done);
        n_tests++;
        if (int'(R2R_output) != code || int'(ramp_dir) != dir ||
            int'(step_strobe) != stp || int'(sweep_done) != done) begin
            n_fail++;
            $display("FAIL %s: got code=%0d dir=%0d step=%0d done=%0d expected code=%0d dir=%0d step=%0d done=%0d at %0t",
                     name, R2R_output, ramp_dir, step_strobe, sweep_done,
                     code, dir, stp, done, $time);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge(restart, enable, triangle_mode);
        #1;
        check_outputs("model", m_code(), m_dir(), m_step, m_done);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        logic  rs;
        logic  en;
        logic  tm;
        int    ncyc;
        int    code;
        int    dir;
        int    stp;
        int    done;
        string name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        tbl.push_back('{1'b0, 1'b1, 1'b0,    4,   1, 0, 1, 0, "first_step_edge4"});
        tbl.push_back('{1'b0, 1'b1, 1'b0,    4,   2, 0, 1, 0, "second_step_edge8"});
        tbl.push_back('{1'b0, 1'b1, 1'b0,    1,   2, 0, 0, 0, "no_strobe_between"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1015,   0, 0, 1, 1, "saw_wrap_edge1024"});
        tbl.push_back('{1'b1, 1'b1, 1'b1,    1,   0, 0, 0, 0, "restart_to_tri"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1020, 255, 0, 1, 0, "tri_peak"});
        tbl.push_back('{1'b0, 1'b1, 1'b1,    4, 254, 1, 1, 0, "tri_turn_down"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1016,   0, 1, 1, 1, "tri_sweep_done_2040"});
        tbl.push_back('{1'b0, 1'b1, 1'b1,    4,   1, 0, 1, 0, "tri_turn_up"});

        reset         = 1'b0;
        enable        = 1'b1;
        restart       = 1'b0;
        triangle_mode = 1'b0;
        run(3);
        check_outputs("reset_state", 0, 0, 0, 0);
        reset = 1'b1;

        foreach (tbl[i]) begin
            restart       = tbl[i].rs;
            enable        = tbl[i].en;
            triangle_mode = tbl[i].tm;
            run(tbl[i].ncyc);
            check_outputs(tbl[i].name, tbl[i].code, tbl[i].dir, tbl[i].stp, tbl[i].done);
        end

        // Pause at code 100 with prescaler at 2, then resume from the held count.
        restart = 1'b1; triangle_mode = 1'b0; enable = 1'b1;
        run(1);
        restart = 1'b0;
        run(402);
        check("pause_start_code", int'(R2R_output), 100);
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            check("pause_hold_code", int'(R2R_output), 100);
            check("pause_no_strobe", int'(step_strobe) + int'(sweep_done), 0);
        end
        enable = 1'b1;
        run(1);
        check("resume_1_cycle", int'(R2R_output), 100);
        run(1);
        check_outputs("resume_2_cycles", 101, 0, 1, 0);

        // Restart coincident with a due step at code 200.
        restart = 1'b1;
        run(1);
        restart = 1'b0;
        run(803);
        check("pre_restart_code", int'(R2R_output), 200);
        restart = 1'b1;
        run(1);
        check_outputs("restart_beats_step", 0, 0, 0, 0);
        restart = 1'b0;
        run(3);
        check("restart_hold3", int'(R2R_output), 0);
        run(1);
        check_outputs("restart_first_step", 1, 0, 1, 0);

        // Mid-sweep mode change only takes effect at the sawtooth wrap.
        restart = 1'b1; triangle_mode = 1'b0;
        run(1);
        restart = 1'b0;
        run(200);
        check("switch_at_50", int'(R2R_output), 50);
        triangle_mode = 1'b1;
        run(824);
        check_outputs("switch_saw_wrap", 0, 0, 1, 1);
        run(4);
        check_outputs("switch_tri_1", 1, 0, 1, 0);
        run(1016);
        check_outputs("switch_tri_255", 255, 0, 1, 0);
        run(4);
        check_outputs("switch_tri_254", 254, 1, 1, 0);

        // Asynchronous reset mid triangle descent.
        restart = 1'b1; triangle_mode = 1'b1;
        run(1);
        restart = 1'b0;
        run(1320);
        check_outputs("tri_down_180", 180, 1, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_reset_immediate", 0, 0, 0, 0);
        model_reset();
        run(2);
        reset = 1'b1;
        run(1020);
        check_outputs("post_reset_saw_255", 255, 0, 1, 0);
        run(4);
        check_outputs("post_reset_saw_wrap", 0, 0, 1, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 299) == 0) triangle_mode = ~triangle_mode;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
